// File: rtl/tick_gen.sv
// tick_gen: programmable one-shot / periodic tick source.
// A valid start latches a period and mode. The block then emits a one-cycle
// tick each time the countdown reaches zero.
module tick_gen #(
  parameter int MAX_PERIOD = 256,
  parameter int WIDTH      = $clog2(MAX_PERIOD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] remaining,
  output logic             err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One extra bit on the bound, so a MAX_PERIOD that fills WIDTH compares correctly.
  localparam logic [WIDTH:0] MAX_P_EXT = (WIDTH + 1)'(MAX_PERIOD);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic             start_ok;

  // A start is accepted only for a period in 1..MAX_PERIOD.
  always_comb begin
    start_ok = (period != '0) && ({1'b0, period} <= MAX_P_EXT);
  end

  // Next-state logic. Priority order is stop, valid start, rejected start, countdown.
  // A rejected start only raises err and lets a running countdown continue untouched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (start && start_ok) begin
      per_d   = period;
      mode_d  = mode;
      cnt_d   = period - WIDTH'(1);
      state_d = RUN;
    end else begin
      err_d = start;
      if (state_q == RUN) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else if (mode_q) begin
          cnt_d = per_q - WIDTH'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  // Outputs are decoded from registers only, so no input reaches them combinationally.
  always_comb begin
    busy      = (state_q == RUN);
    tick      = busy && (cnt_q == '0);
    remaining = busy ? cnt_q : '0;
    err       = err_q;
  end

endmodule

// File: tb/tb_tick_gen.sv
// Directed testbench for tick_gen with hand-computed expected values.
module tb_tick_gen;

  localparam int MAXP = 256;
  localparam int W    = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] period = '0;
  logic         tick;
  logic         busy;
  logic [W-1:0] remaining;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  tick_gen #(.MAX_PERIOD(MAXP), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .mode(mode),
    .period(period),
    .tick(tick),
    .busy(busy),
    .remaining(remaining),
    .err(err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Drive inputs for the current cycle, then move to the next cycle (sampled 1 unit after the edge).
  task automatic applyStimulus(input logic s, input logic p, input logic m, input logic [W-1:0] per);
    start  = s;
    stop   = p;
    mode   = m;
    period = per;
    @(posedge clk);
    #1;
    start  = 1'b0;
    stop   = 1'b0;
  endtask

  // Compare all four outputs against the expected values.
  task automatic checkOutput(input string tag, input logic e_tick, input logic e_busy,
                             input logic [W-1:0] e_rem, input logic e_err);
    n_checks++;
    assert (tick === e_tick) else begin
      n_fail++;
      $error("[TB] FAIL %s.tick: observed %b expected %b", tag, tick, e_tick);
    end
    n_checks++;
    assert (busy === e_busy) else begin
      n_fail++;
      $error("[TB] FAIL %s.busy: observed %b expected %b", tag, busy, e_busy);
    end
    n_checks++;
    assert (remaining === e_rem) else begin
      n_fail++;
      $error("[TB] FAIL %s.remaining: observed %0d expected %0d", tag, remaining, e_rem);
    end
    n_checks++;
    assert (err === e_err) else begin
      n_fail++;
      $error("[TB] FAIL %s.err: observed %b expected %b", tag, err, e_err);
    end
  endtask

  // Linear sequence of directed steps.
  initial begin
    // Reset held low: everything at zero.
    #2;
    checkOutput("reset_hold", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("reset_edge", 0, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    checkOutput("after_reset", 0, 0, 0, 0);

    // Periodic, period 4: remaining 3,2,1,0 repeating; ticks in cycles 4, 8, 12.
    applyStimulus(1, 0, 1, 9'd4);
    for (int c = 1; c <= 12; c++) begin
      logic [W-1:0] r;
      r = W'(3 - ((c - 1) % 4));
      checkOutput($sformatf("per4_c%0d", c), (c % 4) == 0, 1, r, 0);
      if (c < 12) applyStimulus(0, 0, 0, 0);
    end
    applyStimulus(0, 1, 0, 0);
    checkOutput("per4_stopped", 0, 0, 0, 0);

    // One-shot, period 1: tick and busy in cycle 1 only.
    applyStimulus(1, 0, 0, 9'd1);
    checkOutput("os1_c1", 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("os1_c2", 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("os1_c3", 0, 0, 0, 0);

    // One-shot, period 3: busy in cycles 1..3, tick in cycle 3, idle from cycle 4.
    applyStimulus(1, 0, 0, 9'd3);
    checkOutput("os3_c1", 0, 1, 2, 0);
    applyStimulus(0, 0, 1, 9'd7);
    checkOutput("os3_c2", 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("os3_c3", 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("os3_c4", 0, 0, 0, 0);

    // Periodic 5, re-armed with period 2 in cycle 7: ticks in 5, 9, 11, 13.
    applyStimulus(1, 0, 1, 9'd5);
    checkOutput("rearm_c1", 0, 1, 4, 0);
    for (int c = 2; c <= 7; c++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput($sformatf("rearm_c%0d", c), c == 5, 1, W'(c <= 5 ? 5 - c : 10 - c), 0);
    end
    applyStimulus(1, 0, 1, 9'd2);
    checkOutput("rearm_c8", 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rearm_c9", 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rearm_c10", 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rearm_c11", 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rearm_c12", 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rearm_c13", 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("rearm_stopped", 0, 0, 0, 0);

    // Periodic 3, rejected start (period 0) in cycle 1: err in cycle 2 and the cadence is unchanged.
    applyStimulus(1, 0, 1, 9'd3);
    checkOutput("rej_c1", 0, 1, 2, 0);
    applyStimulus(1, 0, 0, 9'd0);
    checkOutput("rej_c2", 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rej_c3", 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rej_c4", 0, 1, 2, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rej_c5", 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rej_c6", 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("rej_stopped", 0, 0, 0, 0);

    // Start with period MAX_PERIOD+1 from IDLE: err pulses and busy stays low.
    applyStimulus(1, 0, 1, 9'd257);
    checkOutput("over_c1", 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("over_c2", 0, 0, 0, 0);

    // MAX_PERIOD itself is accepted.
    applyStimulus(1, 0, 0, 9'd256);
    checkOutput("maxp_c1", 0, 1, 255, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("maxp_stopped", 0, 0, 0, 0);

    // stop+start together in a tick cycle: the tick shows, then the timer is idle and err stays low.
    applyStimulus(1, 0, 1, 9'd2);
    checkOutput("ss_c1", 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("ss_c2", 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 9'd3);
    checkOutput("ss_c3", 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("ss_c4", 0, 0, 0, 0);

    // Periodic 3, reset pulled low in cycle 2 for two cycles: outputs drop at once, no ticks afterwards.
    applyStimulus(1, 0, 1, 9'd3);
    checkOutput("rst_c1", 0, 1, 2, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rst_c2", 0, 1, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_async", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("rst_held", 0, 0, 0, 0);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput($sformatf("rst_after_c%0d", c), 0, 0, 0, 0);
    end

    // Periodic period 1 after reset: a tick every cycle.
    applyStimulus(1, 0, 1, 9'd1);
    checkOutput("p1_c1", 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("p1_c2", 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("p1_c3", 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("p1_stopped", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
